// File: rtl/csr_write_sequencer.sv
// Drains a bundle of up to three CSR writes onto a single CSR write port in slot order,
// with a pipeline ready handshake and a pending-write lookup for the CSR read stage.
module csr_write_sequencer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_en,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [ADDR_W-1:0] in_addr2,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic              csr_wready,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit,
  output logic [DATA_W-1:0] chk_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned NSLOT = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NSLOT-1:0]    pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q [NSLOT];
  logic [ADDR_W-1:0]   addr_d [NSLOT];
  logic [DATA_W-1:0]   data_q [NSLOT];
  logic [DATA_W-1:0]   data_d [NSLOT];
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;
  logic                in_ready_q, in_ready_d;
  logic [1:0]          sel;
  logic                we;

  // Lowest-index pending slot is the one on the write port
  always_comb begin
    sel = 2'd0;
    if (pending_q[0])      sel = 2'd0;
    else if (pending_q[1]) sel = 2'd1;
    else                   sel = 2'd2;
  end

  assign we = (state_q == DRAIN) && (pending_q != '0);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          pending_d = in_en;
          addr_d[0] = in_addr0;
          addr_d[1] = in_addr1;
          addr_d[2] = in_addr2;
          data_d[0] = in_data0;
          data_d[1] = in_data1;
          data_d[2] = in_data2;
          if (in_en != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!we) begin
          state_d = IDLE;
        end else if (csr_wready) begin
          pending_d[sel] = 1'b0;
          wr_count_d     = wr_count_q + CNT_W'(1);
          if (pending_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      addr_q     <= '{default: '0};
      data_q     <= '{default: '0};
      wr_count_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign csr_we    = we;
  assign csr_waddr = we ? addr_q[sel] : '0;
  assign csr_wdata = we ? data_q[sel] : '0;
  assign wr_count  = wr_count_q;

  // Higher slot overrides lower: it is the value the CSR will finally hold
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (pending_q[i] && (addr_q[i] == chk_addr)) begin
        chk_hit  = 1'b1;
        chk_data = data_q[i];
      end
    end
  end

endmodule
